// File: rtl/match_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : match_ctrl_if
//  Description : Physics-engine result/enable bundle between the game-flow
//                controller and the physics engine.
//                  phys_en        - one-cycle physics update enable (ctrl -> engine)
//                  phys_valid     - result valid (engine -> ctrl)
//                  phys_game_over - ball touched the floor, qualified by valid
//                  phys_winner    - 1 = P1 scores, 2 = P2 scores, 0/3 = none
//                Modport master is the controller side, slave the engine side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface match_ctrl_if;
    logic       phys_en;
    logic       phys_valid;
    logic       phys_game_over;
    logic [1:0] phys_winner;

    modport master (
        output phys_en,
        input  phys_valid,
        input  phys_game_over,
        input  phys_winner
    );

    modport slave (
        input  phys_en,
        output phys_valid,
        output phys_game_over,
        output phys_winner
    );
endinterface
`default_nettype wire

// File: rtl/match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : match_ctrl
//  Description : Game-flow controller on the consumer side of the physics
//                engine. Generates the free-running frame tick, gates the
//                per-frame physics enable during rallies, accepts scored
//                points, keeps both scores and sequences
//                IDLE -> SERVE -> PLAY -> POINT / MATCH_OVER.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                start             - one-cycle start-button pulse
//                phys (master)     - physics enable out / results in
//                frame_tick        - one-cycle pulse per frame
//                p1_score/p2_score - player points (5 bits)
//                state             - 0 IDLE,1 SERVE,2 PLAY,3 POINT,4 MATCH_OVER
//                score_evt         - one-cycle pulse when a score changes
//                match_winner      - 0 none, 1 P1, 2 P2 (valid in MATCH_OVER)
//  Revision    : 1.0 - initial release
// ============================================================================
module match_ctrl #(
    parameter int FRAME_DIV    = 1666666,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int WIN_SCORE    = 15
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start,
    match_ctrl_if.master     phys,
    output logic             frame_tick,
    output logic [4:0]       p1_score,
    output logic [4:0]       p2_score,
    output logic [2:0]       state,
    output logic             score_evt,
    output logic [1:0]       match_winner
);

    localparam int FD_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int SFC_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int SFC_W   = $clog2(SFC_MAX + 1);

    localparam logic [FD_W-1:0]  c_FRAME_LAST = FD_W'(FRAME_DIV - 1);
    localparam logic [SFC_W-1:0] c_SERVE_LAST = SFC_W'(SERVE_FRAMES - 1);
    localparam logic [SFC_W-1:0] c_POINT_LAST = SFC_W'(POINT_FRAMES - 1);
    localparam logic [4:0]       c_WIN_SCORE  = 5'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SERVE      = 3'd1,
        S_PLAY       = 3'd2,
        S_POINT      = 3'd3,
        S_MATCH_OVER = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [FD_W-1:0]   r_frame_cnt;
    logic              r_frame_tick;
    logic [SFC_W-1:0]  r_sfc;
    logic [4:0]        r_p1;
    logic [4:0]        r_p2;
    logic [1:0]        r_winner;
    logic              r_score_evt;
    logic              r_phys_en;

    logic              w_accept;
    logic [4:0]        w_p1_inc;
    logic [4:0]        w_p2_inc;
    logic [4:0]        w_p1_next;
    logic [4:0]        w_p2_next;
    logic [1:0]        w_winner_next;
    logic              w_score_evt_next;
    logic              w_phys_en_next;

    // ------------------------------------------------------------------
    // Free-running frame divider; the tick is registered so it appears in
    // the cycle after the counter sits on its last value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= (r_frame_cnt == c_FRAME_LAST);
            if (r_frame_cnt == c_FRAME_LAST) begin
                r_frame_cnt <= '0;
            end else begin
                r_frame_cnt <= r_frame_cnt + FD_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, score and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_p1_next        = r_p1;
        w_p2_next        = r_p2;
        w_winner_next    = r_winner;
        w_score_evt_next = 1'b0;
        w_p1_inc         = r_p1 + 5'd1;
        w_p2_inc         = r_p2 + 5'd1;

        // Only a real winner code during a rally counts as a point.
        w_accept = (r_state == S_PLAY) && phys.phys_valid && phys.phys_game_over &&
                   ((phys.phys_winner == 2'd1) || (phys.phys_winner == 2'd2));

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SERVE;
                end
            end
            S_SERVE: begin
                if (r_frame_tick && (r_sfc == c_SERVE_LAST)) begin
                    w_state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                if (w_accept) begin
                    w_score_evt_next = 1'b1;
                    if (phys.phys_winner == 2'd1) begin
                        w_p1_next = w_p1_inc;
                        if (w_p1_inc == c_WIN_SCORE) begin
                            w_state_next  = S_MATCH_OVER;
                            w_winner_next = 2'd1;
                        end else begin
                            w_state_next = S_POINT;
                        end
                    end else begin
                        w_p2_next = w_p2_inc;
                        if (w_p2_inc == c_WIN_SCORE) begin
                            w_state_next  = S_MATCH_OVER;
                            w_winner_next = 2'd2;
                        end else begin
                            w_state_next = S_POINT;
                        end
                    end
                end
            end
            S_POINT: begin
                if (r_frame_tick && (r_sfc == c_POINT_LAST)) begin
                    w_state_next = S_SERVE;
                end
            end
            S_MATCH_OVER: begin
                // A new match clears the board; the clear is itself a score change.
                if (start) begin
                    w_state_next     = S_SERVE;
                    w_p1_next        = 5'd0;
                    w_p2_next        = 5'd0;
                    w_winner_next    = 2'd0;
                    w_score_evt_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // A point scored on the tick cycle ends the rally, so no update follows.
        w_phys_en_next = r_frame_tick && (r_state == S_PLAY) && !w_accept;
    end

    // ------------------------------------------------------------------
    // Scores, per-state frame counter and registered pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1        <= 5'd0;
            r_p2        <= 5'd0;
            r_winner    <= 2'd0;
            r_score_evt <= 1'b0;
            r_phys_en   <= 1'b0;
            r_sfc       <= '0;
        end else begin
            r_p1        <= w_p1_next;
            r_p2        <= w_p2_next;
            r_winner    <= w_winner_next;
            r_score_evt <= w_score_evt_next;
            r_phys_en   <= w_phys_en_next;
            if (w_state_next != r_state) begin
                r_sfc <= '0;
            end else if (r_frame_tick) begin
                r_sfc <= r_sfc + SFC_W'(1);
            end
        end
    end

    assign phys.phys_en  = r_phys_en;
    assign frame_tick    = r_frame_tick;
    assign p1_score      = r_p1;
    assign p2_score      = r_p2;
    assign state         = r_state;
    assign score_evt     = r_score_evt;
    assign match_winner  = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_match_ctrl
//  Description : Directed self-checking bench for match_ctrl with small
//                frame/serve/point/win parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_match_ctrl;

    localparam int FRAME_DIV    = 4;
    localparam int SERVE_FRAMES = 2;
    localparam int POINT_FRAMES = 3;
    localparam int WIN_SCORE    = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       frame_tick;
    logic [4:0] p1_score;
    logic [4:0] p2_score;
    logic [2:0] state;
    logic       score_evt;
    logic [1:0] match_winner;

    int n_total = 0;
    int n_pass  = 0;

    match_ctrl_if phys_bus ();

    match_ctrl #(
        .FRAME_DIV    (FRAME_DIV),
        .SERVE_FRAMES (SERVE_FRAMES),
        .POINT_FRAMES (POINT_FRAMES),
        .WIN_SCORE    (WIN_SCORE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .phys         (phys_bus),
        .frame_tick   (frame_tick),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .state        (state),
        .score_evt    (score_evt),
        .match_winner (match_winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic g, input logic [1:0] w);
        phys_bus.phys_valid     = v;
        phys_bus.phys_game_over = g;
        phys_bus.phys_winner    = w;
    endtask

    task automatic wait_tick(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (state == s) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    // Enable must follow a PLAY tick by exactly one cycle and last one cycle.
    task automatic pe_cycle(input string tag);
        wait_tick({tag, "_tick"});
        check({tag, "_pe_at_tick"}, 32'(phys_bus.phys_en), 32'd0);
        step();
        check({tag, "_pe_after"}, 32'(phys_bus.phys_en), 32'd1);
        step();
        check({tag, "_pe_drop"}, 32'(phys_bus.phys_en), 32'd0);
    endtask

    task automatic score_point(input string tag, input logic [1:0] w,
                               input logic [4:0] e1, input logic [4:0] e2,
                               input logic [2:0] es, input logic [1:0] emw);
        drive(1'b1, 1'b1, w);
        step();
        drive(1'b0, 1'b0, 2'd0);
        check({tag, "_p1"},    32'(p1_score),     32'(e1));
        check({tag, "_p2"},    32'(p2_score),     32'(e2));
        check({tag, "_state"}, 32'(state),        32'(es));
        check({tag, "_evt"},   32'(score_evt),    32'd1);
        check({tag, "_mw"},    32'(match_winner), 32'(emw));
        step();
        check({tag, "_evt_drop"}, 32'(score_evt), 32'd0);
        if (es == 3'd3) begin
            wait_state({tag, "_back_to_play"}, 3'd2, 60);
        end
    endtask

    initial begin
        int n3;
        int n1;
        int npe;
        int nev;
        bit ok;

        rst   = 1'b1;
        start = 1'b0;
        drive(1'b0, 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        step();

        // Reset state
        check("rst_state", 32'(state),            32'd0);
        check("rst_p1",    32'(p1_score),         32'd0);
        check("rst_p2",    32'(p2_score),         32'd0);
        check("rst_pe",    32'(phys_bus.phys_en), 32'd0);
        check("rst_tick",  32'(frame_tick),       32'd0);
        check("rst_evt",   32'(score_evt),        32'd0);
        check("rst_mw",    32'(match_winner),     32'd0);
        rst = 1'b0;

        // 1: idle for 20 cycles, tick every 4th cycle
        for (int i = 0; i < 20; i++) begin
            step();
            check("t1_tick",  32'(frame_tick),       32'((i % 4) == 3));
            check("t1_state", 32'(state),            32'd0);
            check("t1_pe",    32'(phys_bus.phys_en), 32'd0);
        end
        check("t1_p1", 32'(p1_score), 32'd0);
        check("t1_p2", 32'(p2_score), 32'd0);

        // 2: start -> SERVE for two ticks -> PLAY, then per-frame enables
        start = 1'b1;
        step();
        start = 1'b0;
        check("t2_serve", 32'(state), 32'd1);
        wait_tick("t2_tick1");
        check("t2_serve_tick1", 32'(state), 32'd1);
        step();
        check("t2_serve_after1", 32'(state), 32'd1);
        wait_tick("t2_tick2");
        check("t2_serve_tick2", 32'(state), 32'd1);
        step();
        check("t2_play", 32'(state), 32'd2);
        check("t2_no_pe_on_entry", 32'(phys_bus.phys_en), 32'd0);
        pe_cycle("t2_a");
        pe_cycle("t2_b");

        // 3: P2 scores; POINT for 3 ticks, SERVE for 2, then PLAY
        drive(1'b1, 1'b1, 2'd2);
        step();
        drive(1'b0, 1'b0, 2'd0);
        check("t3_p2",    32'(p2_score),  32'd1);
        check("t3_p1",    32'(p1_score),  32'd0);
        check("t3_evt",   32'(score_evt), 32'd1);
        check("t3_state", 32'(state),     32'd3);
        n3 = 0; n1 = 0; npe = 0; nev = 0; ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (frame_tick && state == 3'd3) n3++;
            if (frame_tick && state == 3'd1) n1++;
            if (phys_bus.phys_en) npe++;
            if (score_evt) nev++;
            if (state == 3'd2) begin
                ok = 1'b1;
                break;
            end
        end
        check("t3_reached_play", 32'(ok),  32'd1);
        check("t3_point_ticks",  32'(n3),  32'd3);
        check("t3_serve_ticks",  32'(n1),  32'd2);
        check("t3_no_pe",        32'(npe), 32'd0);
        check("t3_evt_single",   32'(nev), 32'd0);

        // 4: non-scoring results are ignored; point on a tick suppresses enable
        drive(1'b1, 1'b1, 2'd0);
        step();
        check("t4_w0_state", 32'(state),    32'd2);
        check("t4_w0_p2",    32'(p2_score), 32'd1);
        check("t4_w0_evt",   32'(score_evt), 32'd0);
        drive(1'b1, 1'b1, 2'd3);
        step();
        check("t4_w3_state", 32'(state),    32'd2);
        drive(1'b0, 1'b1, 2'd2);
        step();
        drive(1'b0, 1'b0, 2'd0);
        check("t4_nv_state", 32'(state),    32'd2);
        check("t4_nv_p2",    32'(p2_score), 32'd1);
        check("t4_nv_evt",   32'(score_evt), 32'd0);
        wait_tick("t4_tick");
        check("t4_tick_in_play", 32'(state), 32'd2);
        drive(1'b1, 1'b1, 2'd2);
        step();
        drive(1'b0, 1'b0, 2'd0);
        check("t4_coll_pe",    32'(phys_bus.phys_en), 32'd0);
        check("t4_coll_p2",    32'(p2_score),         32'd2);
        check("t4_coll_state", 32'(state),            32'd3);
        check("t4_coll_evt",   32'(score_evt),        32'd1);
        wait_state("t4_back_to_play", 3'd2, 60);

        // 5: P1 to 3 points -> MATCH_OVER
        score_point("t5_pt1", 2'd1, 5'd1, 5'd2, 3'd3, 2'd0);
        score_point("t5_pt2", 2'd1, 5'd2, 5'd2, 3'd3, 2'd0);
        score_point("t5_pt3", 2'd1, 5'd3, 5'd2, 3'd4, 2'd1);
        drive(1'b1, 1'b1, 2'd2);
        step();
        drive(1'b1, 1'b1, 2'd1);
        step();
        drive(1'b0, 1'b0, 2'd0);
        npe = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (phys_bus.phys_en) npe++;
        end
        check("t5_mo_p1",    32'(p1_score),     32'd3);
        check("t5_mo_p2",    32'(p2_score),     32'd2);
        check("t5_mo_state", 32'(state),        32'd4);
        check("t5_mo_mw",    32'(match_winner), 32'd1);
        check("t5_mo_no_pe", 32'(npe),          32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_new_state", 32'(state),        32'd1);
        check("t5_new_p1",    32'(p1_score),     32'd0);
        check("t5_new_p2",    32'(p2_score),     32'd0);
        check("t5_new_mw",    32'(match_winner), 32'd0);

        // 6: reset in the middle of a rally with P1 on 2 points
        wait_state("t6_play", 3'd2, 60);
        score_point("t6_pt1", 2'd1, 5'd1, 5'd0, 3'd3, 2'd0);
        score_point("t6_pt2", 2'd1, 5'd2, 5'd0, 3'd3, 2'd0);
        wait_tick("t6_tick");
        check("t6_pre_state", 32'(state),    32'd2);
        check("t6_pre_p1",    32'(p1_score), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_state", 32'(state),            32'd0);
        check("t6_p1",    32'(p1_score),         32'd0);
        check("t6_p2",    32'(p2_score),         32'd0);
        check("t6_pe",    32'(phys_bus.phys_en), 32'd0);
        check("t6_tick",  32'(frame_tick),       32'd0);
        check("t6_evt",   32'(score_evt),        32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_restart_tick", 32'(frame_tick), 32'(i == 3));
        end
        npe = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (phys_bus.phys_en) npe++;
        end
        check("t6_no_pe",     32'(npe),   32'd0);
        check("t6_idle_hold", 32'(state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
